spi_bus_arbiter: RTL and testbench

//  Shares one physical SPI bus (sclk/mosi/miso) between NUM_MASTERS SPI controllers (ADC sequencer, DAC, flash).

---
 rtl/spi_bus_arbiter_if.sv | 27 ++
 rtl/spi_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_spi_bus_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// rtl/spi_bus_arbiter_if.sv - master-side and shared-bus signals of the SPI bus arbiter
interface spi_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2
) ();
   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] gnt;
   logic [NUM_MASTERS-1:0] m_csel;
   logic [NUM_MASTERS-1:0] m_sclk;
   logic [NUM_MASTERS-1:0] m_mosi;
   logic [NUM_MASTERS-1:0] m_miso;
   logic [NUM_MASTERS-1:0] bus_csel;
   logic                   bus_sclk;
   logic                   bus_mosi;
   logic                   bus_miso;
   logic                   busy;
   logic                   proto_err;

   modport slave (
      input  req, m_csel, m_sclk, m_mosi, bus_miso,
      output gnt, m_miso, bus_csel, bus_sclk, bus_mosi, busy, proto_err
   );

   modport master (
      output req, m_csel, m_sclk, m_mosi, bus_miso,
      input  gnt, m_miso, bus_csel, bus_sclk, bus_mosi, busy, proto_err
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin sharing of one SPI bus between several controllers
// Grants change only at transaction boundaries and are always followed by an idle guard gap.
module spi_bus_arbiter #(
   parameter int NUM_MASTERS     = 2,
   parameter int GAP_CYCLES      = 4,
   parameter int MAX_HOLD_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   spi_bus_arbiter_if.slave bus_if
);
   localparam int          IW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] HOLD_MAX = 16'(MAX_HOLD_CYCLES);
   localparam bit          HOLD_EN  = (MAX_HOLD_CYCLES != 0);

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

   state_e                 state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [NUM_MASTERS-1:0] csel_q, csel_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [15:0]            hold_q, hold_d;
   logic [15:0]            gap_q, gap_d;
   logic                   expired_q, expired_d;
   logic                   sclk_q, sclk_d;
   logic                   mosi_q, mosi_d;
   logic                   perr_q, perr_d;
   logic [IW-1:0]          pick, cand;
   logic                   found;
   logic                   timeout;

   // expired_q tracks hold_q >= HOLD_MAX without a magnitude compare
   assign timeout = HOLD_EN && expired_q && bus_if.m_csel[idx_q]
                    && (|(bus_if.req & ~gnt_q));

   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      cand  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = IW'((int'(ptr_q) + i) % NUM_MASTERS);
         if (!found && bus_if.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      expired_d = expired_q;
      gap_d     = gap_q;
      csel_d    = '1;
      sclk_d    = 1'b0;
      mosi_d    = 1'b0;
      perr_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d     = ST_GRANT;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               idx_d       = pick;
               ptr_d       = (int'(pick) == NUM_MASTERS - 1) ? '0 : pick + 1'b1;
               hold_d      = '0;
               expired_d   = 1'b0;
            end
         end
         ST_GRANT: begin
            if (!bus_if.req[idx_q] || timeout) begin
               perr_d  = !bus_if.req[idx_q] && !bus_if.m_csel[idx_q];
               state_d = ST_GAP;
               gnt_d   = '0;
               gap_d   = '0;
            end else begin
               csel_d[idx_q] = bus_if.m_csel[idx_q];
               sclk_d        = bus_if.m_sclk[idx_q];
               mosi_d        = bus_if.m_mosi[idx_q];
               hold_d        = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
               expired_d     = expired_q || (hold_d == HOLD_MAX);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         expired_q <= 1'b0;
         gap_q     <= '0;
         csel_q    <= '1;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         expired_q <= expired_d;
         gap_q     <= gap_d;
         csel_q    <= csel_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         perr_q    <= perr_d;
      end
   end

   assign bus_if.gnt       = gnt_q;
   assign bus_if.bus_csel  = csel_q;
   assign bus_if.bus_sclk  = sclk_q;
   assign bus_if.bus_mosi  = mosi_q;
   assign bus_if.m_miso    = gnt_q & {NUM_MASTERS{bus_if.bus_miso}};
   assign bus_if.busy      = (state_q != ST_IDLE);
   assign bus_if.proto_err = perr_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - self-checking bench for spi_bus_arbiter
// A cycle-level reference model runs in the background; directed sequences cover the corner cases.
module tb_spi_bus_arbiter;
   localparam int N    = 3;
   localparam int GAP  = 4;
   localparam int MAXH = 100;

   logic clk = 1'b0;
   logic reset;
   logic chk_en = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   spi_bus_arbiter_if #(.NUM_MASTERS(N)) bi ();

   spi_bus_arbiter #(
      .NUM_MASTERS(N),
      .GAP_CYCLES(GAP),
      .MAX_HOLD_CYCLES(MAXH)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus_if(bi.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: owner/gap/priority bookkeeping expressed in plain integers
   int             m_owner, m_gap, m_rr, m_held, k;
   logic [N-1:0]   e_gnt, e_csel;
   logic           e_sclk, e_mosi, e_busy, e_perr;

   always @(posedge clk) begin
      if (reset) begin
         m_owner = -1; m_gap = 0; m_rr = 0; m_held = 0;
         e_gnt = '0; e_csel = '1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_perr = 1'b0;
      end else begin
         e_perr = 1'b0; e_csel = '1; e_sclk = 1'b0; e_mosi = 1'b0;
         if (m_owner >= 0) begin
            if (!bi.req[m_owner]) begin
               e_perr  = !bi.m_csel[m_owner];
               m_owner = -1;
               m_gap   = GAP;
            end else if (MAXH != 0 && m_held >= MAXH && bi.m_csel[m_owner]
                         && (bi.req & ~e_gnt) != '0) begin
               m_owner = -1;
               m_gap   = GAP;
            end else begin
               e_csel[m_owner] = bi.m_csel[m_owner];
               e_sclk          = bi.m_sclk[m_owner];
               e_mosi          = bi.m_mosi[m_owner];
               m_held++;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end else begin
            for (int off = 0; off < N; off++) begin
               k = (m_rr + off) % N;
               if (bi.req[k]) begin
                  m_owner = k;
                  m_rr    = (k + 1) % N;
                  m_held  = 0;
                  break;
               end
            end
         end
         e_gnt = '0;
         if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
         e_busy = (m_owner >= 0) || (m_gap > 0);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model", 32'({bi.gnt, bi.bus_csel, bi.bus_sclk, bi.bus_mosi, bi.busy, bi.proto_err, bi.m_miso}),
               32'({e_gnt, e_csel, e_sclk, e_mosi, e_busy, e_perr, e_gnt & {N{bi.bus_miso}}}));
         check("onehot", 32'($countones(bi.gnt) <= 1), 32'd1);
      end
   end

   typedef struct packed {
      logic [N-1:0] req, csel, sclk, mosi;
      logic [N-1:0] gnt, bcsel;
      logic         bsclk, bmosi, busy, perr;
   } vec_t;

   vec_t        tv [11];
   logic [23:0] frame;
   logic        fbit, early;
   int          gap_n, idle_n, hi_n, guard;
   logic [N-1:0] exp_g;

   initial begin
      reset = 1'b1;
      bi.req = '0; bi.m_csel = '1; bi.m_sclk = '0; bi.m_mosi = '0; bi.bus_miso = 1'b0;

      // req, csel, sclk, mosi | gnt, bus_csel, bus_sclk, bus_mosi, busy, proto_err
      tv[0]  = '{3'b001, 3'b111, 3'b000, 3'b000, 3'b001, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[1]  = '{3'b001, 3'b110, 3'b000, 3'b001, 3'b001, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0};
      tv[2]  = '{3'b001, 3'b110, 3'b001, 3'b000, 3'b001, 3'b110, 1'b1, 1'b0, 1'b1, 1'b0};
      tv[3]  = '{3'b001, 3'b000, 3'b110, 3'b111, 3'b001, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0};
      tv[4]  = '{3'b011, 3'b110, 3'b001, 3'b001, 3'b001, 3'b110, 1'b1, 1'b1, 1'b1, 1'b0};
      tv[5]  = '{3'b010, 3'b110, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1};
      tv[6]  = '{3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[7]  = '{3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[8]  = '{3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[9]  = '{3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[10] = '{3'b010, 3'b111, 3'b000, 3'b000, 3'b010, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0};

      tick(); tick();
      chk_en = 1'b1;
      check("reset_state", 32'({bi.gnt, bi.bus_csel, bi.bus_sclk, bi.bus_mosi, bi.busy, bi.proto_err}),
            32'({3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0}));
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         bi.req = tv[i].req; bi.m_csel = tv[i].csel; bi.m_sclk = tv[i].sclk; bi.m_mosi = tv[i].mosi;
         tick();
         check($sformatf("vec%0d", i),
               32'({bi.gnt, bi.bus_csel, bi.bus_sclk, bi.bus_mosi, bi.busy, bi.proto_err}),
               32'({tv[i].gnt, tv[i].bcsel, tv[i].bsclk, tv[i].bmosi, tv[i].busy, tv[i].perr}));
      end

      // master 1 is granted here: only its m_miso follows the bus
      for (int i = 0; i < 4; i++) begin
         bi.bus_miso = i[0];
         #1;
         check("miso_route", 32'(bi.m_miso), 32'(3'b010 & {N{i[0]}}));
      end

      // reset in the middle of a frame
      bi.m_csel = 3'b101; bi.m_sclk = 3'b010;
      tick();
      reset = 1'b1;
      tick();
      check("reset_midframe", 32'({bi.gnt, bi.bus_csel, bi.bus_sclk, bi.busy}),
            32'({3'b000, 3'b111, 1'b0, 1'b0}));

      // 24-bit frame from master 0 mirrored one cycle late
      reset = 1'b0; bi.req = 3'b001; bi.m_csel = '1; bi.m_sclk = '0; bi.m_mosi = '0;
      tick();
      check("first_grant", 32'(bi.gnt), 32'(3'b001));
      frame = 24'hA5C396;
      for (int b = 0; b < 48; b++) begin
         fbit = frame[23 - b / 2];
         bi.m_csel = 3'b110; bi.m_sclk = {2'b11, b[0]}; bi.m_mosi = {2'b01, fbit};
         tick();
         check("frame_bit", 32'({bi.bus_csel, bi.bus_sclk, bi.bus_mosi}), 32'({3'b110, b[0], fbit}));
      end

      // hold timeout must wait for the frame to end
      reset = 1'b1; tick(); reset = 1'b0;
      bi.req = 3'b001; bi.m_csel = '1;
      tick();
      bi.m_csel = 3'b110; bi.req = 3'b011;
      early = 1'b0;
      for (int c = 0; c < 130; c++) begin
         tick();
         if (bi.gnt !== 3'b001) early = 1'b1;
      end
      check("no_cut_midframe", 32'(early), 32'd0);
      bi.m_csel = 3'b111;
      tick();
      check("timeout_revoke", 32'({bi.gnt, bi.bus_csel, bi.busy, bi.proto_err}),
            32'({3'b000, 3'b111, 1'b1, 1'b0}));
      repeat (4) tick();
      check("timeout_idle", 32'({bi.gnt, bi.busy}), 32'({3'b000, 1'b0}));
      tick();
      check("timeout_next", 32'(bi.gnt), 32'(3'b010));

      // two masters with req held: alternating grants, each cut at the hold limit
      reset = 1'b1; tick(); reset = 1'b0;
      bi.req = 3'b011; bi.m_csel = '1;
      guard = 0;
      for (int g = 0; g < 4; g++) begin
         exp_g  = (g % 2 == 0) ? 3'b001 : 3'b010;
         gap_n  = 0;
         idle_n = 0;
         while (bi.gnt == '0 && guard < 2000) begin
            if (bi.busy) gap_n++; else idle_n++;
            tick();
            guard++;
         end
         check("rr_owner", 32'(bi.gnt), 32'(exp_g));
         if (g > 0) begin
            check("rr_gap", 32'(gap_n), 32'(GAP));
            check("rr_idle", 32'(idle_n), 32'd1);
         end
         hi_n = 0;
         while (bi.gnt == exp_g && guard < 2000) begin
            hi_n++;
            tick();
            guard++;
         end
         check("rr_hold_len", 32'(hi_n), 32'(MAXH + 1));
      end

      // randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         for (int m = 0; m < N; m++) begin
            if ($urandom_range(0, 99) < 2) bi.req[m] = ~bi.req[m];
            if ($urandom_range(0, 7) == 0) bi.m_csel[m] = ~bi.m_csel[m];
         end
         bi.m_sclk   = N'($urandom);
         bi.m_mosi   = N'($urandom);
         bi.bus_miso = 1'($urandom);
         reset       = ($urandom_range(0, 999) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
